// File: rtl/fir_seq_ctrl.sv
// FIR sequencer: issues one datapath op per cycle, 3*NTAPS+3 cycles per sample, one cycle per coefficient load.
// Moore outputs; dr/lc are only sampled in IDLE, EIDLE, STORE and CWAIT, and never stall an operation in flight.
module fir_seq_ctrl #(
   parameter int                 NTAPS     = 4,
   parameter int                 REG_W     = 4,
   parameter logic [NTAPS-1:0]   SIGN_MASK = 4'b1010
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic             dr,
   input  logic             lc,
   input  logic             overflow,
   output logic             cnt_up,
   output logic             clear,
   output logic             modwait,
   output logic [2:0]       op,
   output logic [REG_W-1:0] src1,
   output logic [REG_W-1:0] src2,
   output logic [REG_W-1:0] dest,
   output logic             err,
   output logic             coef_valid
);

   localparam int CW = $clog2(NTAPS + 1);

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_STORE = 4'd1;
   localparam logic [3:0] S_ZERO  = 4'd2;
   localparam logic [3:0] S_SHIFT = 4'd3;
   localparam logic [3:0] S_MUL   = 4'd4;
   localparam logic [3:0] S_ACC   = 4'd5;
   localparam logic [3:0] S_DONE  = 4'd6;
   localparam logic [3:0] S_CLOAD = 4'd7;
   localparam logic [3:0] S_CWAIT = 4'd8;
   localparam logic [3:0] S_EIDLE = 4'd9;

   localparam logic [2:0] OP_NOP   = 3'b000;
   localparam logic [2:0] OP_COPY  = 3'b001;
   localparam logic [2:0] OP_LSAMP = 3'b010;
   localparam logic [2:0] OP_LCOEF = 3'b011;
   localparam logic [2:0] OP_ADD   = 3'b100;
   localparam logic [2:0] OP_SUB   = 3'b101;
   localparam logic [2:0] OP_MUL   = 3'b110;

   localparam logic [CW-1:0]    K_ONE   = CW'(1);
   localparam logic [CW-1:0]    K_LAST  = CW'(NTAPS);
   localparam logic [CW-1:0]    C_LAST  = CW'(NTAPS - 1);
   localparam logic [REG_W-1:0] R_ONE   = REG_W'(1);
   localparam logic [REG_W-1:0] R_IN    = REG_W'(NTAPS + 1);
   localparam logic [REG_W-1:0] R_TMP   = REG_W'(NTAPS + 2);
   localparam logic [REG_W-1:0] R_COEF0 = REG_W'(NTAPS + 3);

   logic [3:0]    state_q, state_d;
   logic [CW-1:0] k_q, k_d;
   logic [CW-1:0] c_q, c_d;
   logic          modwait_q, modwait_d;
   logic          coef_valid_q, coef_valid_d;
   logic          acc_sub;

   always_comb begin
      state_d      = state_q;
      k_d          = k_q;
      c_d          = c_q;
      coef_valid_d = coef_valid_q;
      case (state_q)
         S_IDLE, S_EIDLE: begin
            if (dr) begin
               state_d = S_STORE;
            end else if (lc) begin
               state_d      = S_CLOAD;
               c_d          = '0;
               coef_valid_d = 1'b0;
            end
         end
         S_STORE: state_d = dr ? S_ZERO : S_EIDLE;
         S_ZERO: begin
            state_d = S_SHIFT;
            k_d     = K_ONE;
         end
         S_SHIFT: begin
            if (k_q == K_LAST) begin
               state_d = S_MUL;
               k_d     = K_ONE;
            end else begin
               k_d = k_q + K_ONE;
            end
         end
         S_MUL: state_d = S_ACC;
         S_ACC: begin
            if (overflow) begin
               state_d = S_EIDLE;
            end else if (k_q == K_LAST) begin
               state_d = S_DONE;
            end else begin
               state_d = S_MUL;
               k_d     = k_q + K_ONE;
            end
         end
         S_DONE: state_d = S_IDLE;
         S_CLOAD: begin
            if (c_q == C_LAST) begin
               state_d      = S_IDLE;
               coef_valid_d = 1'b1;
            end else begin
               state_d = S_CWAIT;
               c_d     = c_q + K_ONE;
            end
         end
         S_CWAIT: begin
            // A sample arriving mid-load aborts the whole coefficient set.
            if (dr) begin
               state_d      = S_EIDLE;
               coef_valid_d = 1'b0;
            end else if (lc) begin
               state_d = S_CLOAD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign modwait_d = (state_d == S_STORE) || (state_d == S_ZERO) || (state_d == S_SHIFT) ||
                      (state_d == S_MUL)   || (state_d == S_ACC)  || (state_d == S_DONE)  ||
                      (state_d == S_CLOAD);

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q      <= S_IDLE;
         k_q          <= '0;
         c_q          <= '0;
         modwait_q    <= 1'b0;
         coef_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         c_q          <= c_d;
         modwait_q    <= modwait_d;
         coef_valid_q <= coef_valid_d;
      end
   end

   always_comb begin
      acc_sub = 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
         if (k_q == CW'(i + 1)) acc_sub = SIGN_MASK[i];
      end
   end

   always_comb begin
      op     = OP_NOP;
      src1   = '0;
      src2   = '0;
      dest   = '0;
      cnt_up = 1'b0;
      clear  = 1'b0;
      err    = 1'b0;
      case (state_q)
         S_IDLE:  clear = 1'b1;
         S_STORE: begin
            op   = OP_LSAMP;
            dest = R_IN;
         end
         S_ZERO:  op = OP_SUB;
         S_SHIFT: begin
            op     = OP_COPY;
            src1   = REG_W'(k_q) + R_ONE;
            dest   = REG_W'(k_q);
            cnt_up = (k_q == K_ONE);
         end
         S_MUL: begin
            op   = OP_MUL;
            src1 = REG_W'(k_q);
            src2 = R_COEF0 + REG_W'(k_q) - R_ONE;
            dest = R_TMP;
         end
         S_ACC: begin
            op   = acc_sub ? OP_SUB : OP_ADD;
            src2 = R_TMP;
         end
         S_CLOAD: begin
            op   = OP_LCOEF;
            dest = R_COEF0 + REG_W'(c_q);
         end
         S_EIDLE: err = 1'b1;
         default: ;
      endcase
   end

   assign modwait    = modwait_q;
   assign coef_valid = coef_valid_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: per-cycle compare against a queue-of-ops model, plus literal checks and an NTAPS sweep.
module tb_fir_seq_ctrl;

   localparam int N = 4;
   localparam int RW = 4;
   localparam logic [N-1:0] MASK = 4'b1010;

   logic clk = 1'b0;
   logic n_reset, dr, lc, overflow;
   logic cnt_up, clear, modwait, err, coef_valid;
   logic [2:0] op;
   logic [RW-1:0] src1, src2, dest;

   logic dr2, dr8, tie0;
   logic cu2, cl2, mw2, er2, cv2, cu8, cl8, mw8, er8, cv8;
   logic [2:0] op2, op8;
   logic [4:0] s1_2, s2_2, d_2, s1_8, s2_8, d_8;

   int checks = 0;
   int errors = 0;

   initial forever #5 clk = ~clk;

   fir_seq_ctrl #(.NTAPS(N), .REG_W(RW), .SIGN_MASK(MASK)) dut (
      .clk(clk), .n_reset(n_reset), .dr(dr), .lc(lc), .overflow(overflow),
      .cnt_up(cnt_up), .clear(clear), .modwait(modwait), .op(op),
      .src1(src1), .src2(src2), .dest(dest), .err(err), .coef_valid(coef_valid));

   fir_seq_ctrl #(.NTAPS(2), .REG_W(5), .SIGN_MASK(2'b11)) u2 (
      .clk(clk), .n_reset(n_reset), .dr(dr2), .lc(tie0), .overflow(tie0),
      .cnt_up(cu2), .clear(cl2), .modwait(mw2), .op(op2),
      .src1(s1_2), .src2(s2_2), .dest(d_2), .err(er2), .coef_valid(cv2));

   fir_seq_ctrl #(.NTAPS(8), .REG_W(5), .SIGN_MASK(8'hFF)) u8 (
      .clk(clk), .n_reset(n_reset), .dr(dr8), .lc(tie0), .overflow(tie0),
      .cnt_up(cu8), .clear(cl8), .modwait(mw8), .op(op8),
      .src1(s1_8), .src2(s2_8), .dest(d_8), .err(er8), .coef_valid(cv8));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- model: pending ops queue plus resting state ----------------
   typedef struct {
      int op; int s1; int s2; int d; int cu; int clr; int er; int kind;
   } rec_t;

   localparam int K_PLAIN = 0, K_STORE = 1, K_ACC = 2, K_CLOAD = 3;
   localparam int R_IDLE = 0, R_EIDLE = 1, R_CWAIT = 2;

   rec_t q[$];
   int   rest = R_IDLE;
   int   mc   = 0;
   int   mcv  = 0;

   function automatic rec_t mk(int o, int a, int b, int d, int cu, int clr, int er, int kind);
      rec_t r;
      r.op = o; r.s1 = a; r.s2 = b; r.d = d; r.cu = cu; r.clr = clr; r.er = er; r.kind = kind;
      return r;
   endfunction

   task automatic push_sample_path();
      q.push_back(mk(2, 0, 0, N + 1, 0, 0, 0, K_STORE));
      q.push_back(mk(5, 0, 0, 0, 0, 0, 0, K_PLAIN));
      for (int t = 1; t <= N; t++) q.push_back(mk(1, t + 1, 0, t, (t == 1) ? 1 : 0, 0, 0, K_PLAIN));
      for (int t = 1; t <= N; t++) begin
         q.push_back(mk(6, t, N + 2 + t, N + 2, 0, 0, 0, K_PLAIN));
         q.push_back(mk(MASK[t-1] ? 5 : 4, 0, N + 2, 0, 0, 0, 0, K_ACC));
      end
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, K_PLAIN));
   endtask

   always @(negedge clk) begin
      rec_t e;
      int   emw;
      if (!n_reset) begin
         q.delete(); rest = R_IDLE; mc = 0; mcv = 0;
      end
      if (q.size() != 0) e = q[0];
      else e = mk(0, 0, 0, 0, 0, (rest == R_IDLE) ? 1 : 0, (rest == R_EIDLE) ? 1 : 0, K_PLAIN);
      emw = (q.size() != 0) ? 1 : 0;
      checks++;
      if (int'(op) != e.op || int'(src1) != e.s1 || int'(src2) != e.s2 || int'(dest) != e.d ||
          int'(cnt_up) != e.cu || int'(clear) != e.clr || int'(err) != e.er ||
          int'(modwait) != emw || int'(coef_valid) != mcv) begin
         errors++;
         $display("FAIL cycle t=%0t: got op=%0d s1=%0d s2=%0d d=%0d cu=%0d clr=%0d err=%0d mw=%0d cv=%0d, expected op=%0d s1=%0d s2=%0d d=%0d cu=%0d clr=%0d err=%0d mw=%0d cv=%0d",
                  $time, op, src1, src2, dest, cnt_up, clear, err, modwait, coef_valid,
                  e.op, e.s1, e.s2, e.d, e.cu, e.clr, e.er, emw, mcv);
      end
      if (n_reset) begin
         if (q.size() != 0) begin
            if (q[0].kind == K_STORE && !dr) begin
               q.delete(); rest = R_EIDLE;
            end else if (q[0].kind == K_ACC && overflow) begin
               q.delete(); rest = R_EIDLE;
            end else if (q[0].kind == K_CLOAD) begin
               void'(q.pop_front());
               if (mc == N - 1) begin rest = R_IDLE; mcv = 1; end
               else begin rest = R_CWAIT; mc++; end
            end else begin
               void'(q.pop_front());
            end
         end else if (dr) begin
            if (rest == R_CWAIT) begin rest = R_EIDLE; mcv = 0; end
            else begin push_sample_path(); rest = R_IDLE; end
         end else if (lc) begin
            if (rest != R_CWAIT) begin mc = 0; mcv = 0; end
            q.push_back(mk(3, 0, 0, N + 3 + mc, 0, 0, 0, K_CLOAD));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_lc(input int i);
      lc = 1'b1;
      cyc();
      chk("cload_op", int'(op), 3);
      chk("cload_dest", int'(dest), 7 + i);
      chk("cload_modwait", int'(modwait), 1);
      lc = 1'b0;
      cyc();
      chk("after_cload_modwait", int'(modwait), 0);
      cyc();
   endtask

   initial begin
      int cnt, muls, c2, c8, sub2, sub8;
      n_reset = 1'b0; dr = 1'b0; lc = 1'b0; overflow = 1'b0;
      dr2 = 1'b0; dr8 = 1'b0; tie0 = 1'b0;
      repeat (3) cyc();
      chk("reset_clear", int'(clear), 1);
      chk("reset_modwait", int'(modwait), 0);
      chk("reset_coef_valid", int'(coef_valid), 0);
      chk("reset_op", int'(op), 0);
      n_reset = 1'b1;
      cyc();

      for (int i = 0; i < 4; i++) pulse_lc(i);
      chk("coef_valid_set", int'(coef_valid), 1);

      // Normal sample with ignored overflow, dr and lc mid-path.
      cnt = 0;
      dr = 1'b1;
      for (int i = 0; i < 30; i++) begin
         cyc();
         if (modwait) cnt++;
         if (i == 1) dr = 1'b0;
         if (i == 3) overflow = 1'b1;
         if (i == 4) overflow = 1'b0;
         if (i == 7) begin lc = 1'b1; dr = 1'b1; end
         if (i == 8) begin lc = 1'b0; dr = 1'b0; end
      end
      chk("sample_modwait_cycles", cnt, 15);
      chk("coef_valid_kept", int'(coef_valid), 1);

      // Single-cycle dr aborts to EIDLE, then normal recovery.
      dr = 1'b1;
      cyc();
      dr = 1'b0;
      cyc();
      chk("short_dr_err", int'(err), 1);
      dr = 1'b1;
      cyc();
      cyc();
      dr = 1'b0;
      chk("recover_err", int'(err), 0);
      repeat (20) cyc();

      // dr and lc together from IDLE: dr wins.
      dr = 1'b1; lc = 1'b1;
      cyc();
      chk("dr_wins_op", int'(op), 2);
      cyc();
      dr = 1'b0; lc = 1'b0;
      repeat (20) cyc();
      chk("dr_wins_coef_valid", int'(coef_valid), 1);

      // Overflow on the second accumulate.
      dr = 1'b1;
      cyc();
      cyc();
      dr = 1'b0;
      repeat (8) cyc();
      chk("acc2_op", int'(op), 5);
      overflow = 1'b1;
      cyc();
      overflow = 1'b0;
      chk("ovf_err", int'(err), 1);
      chk("ovf_modwait", int'(modwait), 0);
      muls = 0;
      for (int i = 0; i < 5; i++) begin
         if (op == 3'b110) muls++;
         cyc();
      end
      chk("ovf_no_mul", muls, 0);

      // Coefficient load aborted by dr in CWAIT.
      lc = 1'b1;
      cyc();
      lc = 1'b0;
      chk("cload0_clears_cv", int'(coef_valid), 0);
      cyc();
      dr = 1'b1;
      cyc();
      dr = 1'b0;
      chk("abort_err", int'(err), 1);
      chk("abort_cv", int'(coef_valid), 0);
      repeat (3) cyc();

      // Reset in SHIFT(k=2).
      dr = 1'b1;
      cyc();
      cyc();
      dr = 1'b0;
      cyc();
      cyc();
      chk("shift2_op", int'(op), 1);
      chk("shift2_dest", int'(dest), 2);
      n_reset = 1'b0;
      #1;
      chk("midreset_clear", int'(clear), 1);
      chk("midreset_modwait", int'(modwait), 0);
      chk("midreset_op", int'(op), 0);
      cyc();
      n_reset = 1'b1;
      repeat (3) cyc();

      // NTAPS sweep.
      c2 = 0; c8 = 0; sub2 = 0; sub8 = 0;
      dr2 = 1'b1; dr8 = 1'b1;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (mw2) c2++;
         if (mw8) c8++;
         if (op2 == 3'b101) sub2++;
         if (op8 == 3'b101) sub8++;
         if (i == 1) begin dr2 = 1'b0; dr8 = 1'b0; end
      end
      chk("n2_latency", c2, 9);
      chk("n8_latency", c8, 27);
      chk("n2_subs", sub2, 3);
      chk("n8_subs", sub8, 9);
      chk("n2_err", int'(er2), 0);
      chk("n8_clear", int'(cl8), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fir_seq_ctrl.md
FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- NTAPS, 4, filter taps, legal 2..8.
- REG_W, 4, register-index width; 2*NTAPS+2 <= 2^REG_W-1 required.
- SIGN_MASK, 4'b1010 (NTAPS bits), bit k-1 set = tap k subtracted, clear = added.

REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- n_reset, in, 1, asynchronous active-low reset.
- dr, in, 1, data ready.
- lc, in, 1, load-coefficient pulse.
- overflow, in, 1, datapath ALU overflow for the current op.
- cnt_up, out, 1, sample-count pulse.
- clear, out, 1, sample-counter clear.
- modwait, out, 1, registered busy flag.
- op, out, 3, datapath opcode.
- src1, src2, dest, out, REG_W each, register indices.
- err, out, 1, error flag.
- coef_valid, out, 1, full coefficient set loaded.

REQ-003 Opcodes SHALL be: 000 NOP, 001 COPY, 010 LOAD_SAMPLE, 011 LOAD_COEF, 100 ADD, 101 SUB, 110 MUL.

REQ-004 Register map SHALL be: 0 accumulator; 1..NTAPS sample history (1 oldest); NTAPS+1 incoming sample (IN); NTAPS+2 product temp (TMP); NTAPS+3+c coefficient c, c=0..NTAPS-1 (COEF(c)).

Function
REQ-005 SHALL implement states IDLE, STORE, ZERO, SHIFT, MUL, ACC, DONE, CLOAD, CWAIT, EIDLE, plus tap counter k and coefficient counter c, each $clog2(NTAPS+1) bits.
REQ-006 Any output not set in a state SHALL be 0. op/src/dest/cnt_up/clear/err SHALL be combinational from state and counters.
REQ-007 IDLE: clear=1, op NOP. dr=1 -> STORE. Else lc=1 -> CLOAD with c=0. Else stay. dr SHALL win when dr and lc are both high.
REQ-008 STORE: op LOAD_SAMPLE, dest IN. dr=1 -> ZERO. dr=0 -> EIDLE.
REQ-009 ZERO: op SUB, src1=src2=dest=0; next SHIFT with k=1.
REQ-010 SHIFT(k): op COPY, src1 k+1, dest k. cnt_up=1 only when k=1. k<NTAPS -> k+1. k=NTAPS -> MUL with k=1.
REQ-011 MUL(k): op MUL, src1 k, src2 COEF(k-1), dest TMP; next ACC(k).
REQ-012 ACC(k): op SUB if SIGN_MASK[k-1] else ADD; src1 0, src2 TMP, dest 0. overflow=1 -> EIDLE. Else k<NTAPS -> MUL(k+1). Else DONE.
REQ-013 DONE: op NOP; next IDLE. The sample path SHALL take exactly 3*NTAPS+3 cycles from STORE entry to DONE exit.
REQ-014 CLOAD(c): op LOAD_COEF, dest COEF(c). c=NTAPS-1 -> IDLE and set coef_valid. Else CWAIT with c+1.
REQ-015 CWAIT: op NOP. lc=1 -> CLOAD(c). dr=1 -> EIDLE, abort load, clear coef_valid. dr SHALL win over lc. Otherwise stay.
REQ-016 EIDLE: err=1, clear=0. Exits are identical to IDLE (dr -> STORE, lc -> CLOAD c=0). err SHALL drop on exit.
REQ-017 modwait SHALL be a flop loaded each cycle with 1 iff the next state is in {STORE, ZERO, SHIFT, MUL, ACC, DONE, CLOAD}. It is therefore high exactly while in those states.
REQ-018 coef_valid SHALL be registered: set on completing CLOAD(NTAPS-1), cleared on CLOAD(0) entry or CWAIT abort. It SHALL NOT gate sample processing.
REQ-019 dr or lc asserted mid-sample-path, or lc during CLOAD, SHALL be ignored. overflow SHALL be ignored outside ACC.

Reset
REQ-020 n_reset low SHALL asynchronously force IDLE, k=c=0, modwait=0, coef_valid=0. Outputs then follow IDLE decode: clear=1, all others 0.
REQ-021 Reset asserted mid-operation SHALL abandon the operation with no further datapath op issued.

Verification
REQ-022 Reset, then 4 lc pulses each 3 cycles apart (NTAPS=4):
- expect dest 7,8,9,10 with op 011;
- modwait high only in CLOAD cycles;
- coef_valid=1 after the 4th.
REQ-023 dr held high 2 cycles from IDLE:
- expect op sequence 010,101, then four 001 (dest 1..4, cnt_up only in the first), then MUL/ADD/MUL/SUB/MUL/ADD/MUL/SUB with src2 7,8,9,10, then NOP;
- modwait high 15 cycles;
- err=0.
REQ-024 dr high 1 cycle only -> STORE then EIDLE with err=1. Next dr returns to normal processing and err=0.
REQ-025 overflow=1 during the 2nd accumulate -> EIDLE next cycle; no further MUL issued; modwait falls.
REQ-026 lc pulse, then dr during CWAIT -> EIDLE, err=1, coef_valid=0. dr and lc together in IDLE -> STORE taken.
REQ-027 n_reset pulsed low during SHIFT(k=2) -> immediate IDLE outputs (clear=1, modwait=0). Parameter sweep NTAPS=2 and 8 (REG_W=5) with SIGN_MASK all-ones checks the 3N+3 latency.
